// File: rtl/dma_burst_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : dma_burst_ctrl_if
// Brief    : Command and burst-output bundle of the DMA burst controller.
// Revision : 1.0
// ----------------------------------------------------------------------------
interface dma_burst_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              start;
    logic [8:0]        length;
    logic [ADDR_W-1:0] base_addr;
    logic              abort;
    logic              go;
    logic              dma_req;
    logic              data_transfer;
    logic [ADDR_W-1:0] addr;
    logic [8:0]        word_cnt;
    logic              busy;
    logic              done;
    logic              err;

    // Command source: issues bursts and watches their progress.
    modport master (
        output start, length, base_addr, abort,
        input  go, dma_req, data_transfer, addr, word_cnt, busy, done, err
    );

    // Burst controller side.
    modport slave (
        input  start, length, base_addr, abort,
        output go, dma_req, data_transfer, addr, word_cnt, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/dma_burst_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : dma_burst_ctrl
// Brief    : Turns a start/length command into a go / dma_req / data_transfer
//            burst with a running word address and count.
// Revision : 1.0
// ----------------------------------------------------------------------------
module dma_burst_ctrl #(
    parameter int ADDR_W    = 16,
    parameter int MAX_WORDS = 256
) (
    input  logic             clk,
    input  logic             reset_n,
    dma_burst_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [9:0] c_max_words = 10'(MAX_WORDS);

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_go,       w_go_nxt;
    logic              r_dma_req,  w_dma_req_nxt;
    logic              r_xfer,     w_xfer_nxt;
    logic              r_done,     w_done_nxt;
    logic              r_err,      w_err_nxt;
    logic              r_busy,     w_busy_nxt;
    logic [ADDR_W-1:0] r_addr,     w_addr_nxt;
    logic [8:0]        r_word_cnt, w_word_cnt_nxt;
    logic [8:0]        r_len,      w_len_nxt;
    logic              r_abort_pend, w_abort_pend_nxt;

    logic              w_len_ok;
    logic [8:0]        w_cnt_inc;
    logic              w_last;

    assign w_len_ok  = (bus.length != 9'd0) && ({1'b0, bus.length} <= c_max_words);
    assign w_cnt_inc = r_word_cnt + 9'd1;
    // An abort seen during REQ is held so it only ends the burst after one word.
    assign w_last    = (w_cnt_inc == r_len) || bus.abort || r_abort_pend;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_go_nxt         = 1'b0;
        w_dma_req_nxt    = 1'b0;
        w_xfer_nxt       = 1'b0;
        w_done_nxt       = 1'b0;
        w_err_nxt        = 1'b0;
        w_busy_nxt       = 1'b1;
        w_addr_nxt       = r_addr;
        w_word_cnt_nxt   = r_word_cnt;
        w_len_nxt        = r_len;
        w_abort_pend_nxt = r_abort_pend;

        case (r_state)
            S_IDLE: begin
                w_busy_nxt = 1'b0;
                if (bus.start) begin
                    if (w_len_ok) begin
                        w_state_nxt      = S_REQ;
                        w_go_nxt         = 1'b1;
                        w_dma_req_nxt    = 1'b1;
                        w_busy_nxt       = 1'b1;
                        w_addr_nxt       = bus.base_addr;
                        w_word_cnt_nxt   = 9'd0;
                        w_len_nxt        = bus.length;
                        w_abort_pend_nxt = 1'b0;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_REQ: begin
                w_state_nxt      = S_XFER;
                w_go_nxt         = 1'b1;
                w_xfer_nxt       = 1'b1;
                w_abort_pend_nxt = bus.abort;
            end
            S_XFER: begin
                w_addr_nxt     = r_addr + ADDR_W'(1);
                w_word_cnt_nxt = w_cnt_inc;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_go_nxt   = 1'b1;
                    w_xfer_nxt = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_go         <= 1'b0;
            r_dma_req    <= 1'b0;
            r_xfer       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_addr       <= '0;
            r_word_cnt   <= 9'd0;
            r_len        <= 9'd0;
            r_abort_pend <= 1'b0;
        end else begin
            r_go         <= w_go_nxt;
            r_dma_req    <= w_dma_req_nxt;
            r_xfer       <= w_xfer_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
            r_busy       <= w_busy_nxt;
            r_addr       <= w_addr_nxt;
            r_word_cnt   <= w_word_cnt_nxt;
            r_len        <= w_len_nxt;
            r_abort_pend <= w_abort_pend_nxt;
        end
    end

    assign bus.go            = r_go;
    assign bus.dma_req       = r_dma_req;
    assign bus.data_transfer = r_xfer;
    assign bus.done          = r_done;
    assign bus.err           = r_err;
    assign bus.busy          = r_busy;
    assign bus.addr          = r_addr;
    assign bus.word_cnt      = r_word_cnt;

endmodule
`default_nettype wire
